// File: rtl/lut_prog_pkg.sv
// Shared definitions for the runtime-programmable LUT neuron.
//   state_t            : controller states (EMPTY, LOAD, RUN)
//   calc_depth         : table depth, 2^IN_BITS
//   calc_ent_per_beat  : table entries carried by one config beat
//   calc_beats         : config beats per complete table
//   calc_cnt_w         : beat counter width, never below 1
package lut_prog_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int calc_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

  function automatic int calc_ent_per_beat(input int cfg_w, input int out_bits);
    return cfg_w / out_bits;
  endfunction

  function automatic int calc_beats(input int in_bits, input int cfg_w, input int out_bits);
    return calc_depth(in_bits) / calc_ent_per_beat(cfg_w, out_bits);
  endfunction

  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/lut_prog_ram.sv
// Truth-table storage for lut_neuron_prog: DEPTH x OUT_BITS distributed RAM.
//   clk, rst  : clock; synchronous active-high reset (clears only the read register)
//   i_we      : write one config beat
//   i_waddr   : beat index; entries written at i_waddr*ENT_PER_BEAT + k
//   i_wdata   : packed entries, entry k in [OUT_BITS*k +: OUT_BITS]
//   i_re      : registered read enable
//   i_raddr   : entry address (neuron input code)
//   o_rdata   : registered read data, holds while i_re is low
// A read and a write on the same edge return the old entry.
module lut_prog_ram
  import lut_prog_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int CFG_W    = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                i_we,
  input  logic [calc_cnt_w(calc_beats(IN_BITS, CFG_W, OUT_BITS))-1:0] i_waddr,
  input  logic [CFG_W-1:0]                                    i_wdata,
  input  logic                                                i_re,
  input  logic [IN_BITS-1:0]                                  i_raddr,
  output logic [OUT_BITS-1:0]                                 o_rdata
);

  localparam int DEPTH        = calc_depth(IN_BITS);
  localparam int ENT_PER_BEAT = calc_ent_per_beat(CFG_W, OUT_BITS);

  (* ram_style = "distributed" *)
  logic [OUT_BITS-1:0] r_mem [DEPTH];

  logic [IN_BITS-1:0] w_base;

  // Truncation to IN_BITS is exact: the largest base is DEPTH - ENT_PER_BEAT.
  assign w_base = IN_BITS'(i_waddr) * IN_BITS'(ENT_PER_BEAT);

  // NOTE: the table array has no reset so it maps onto LUT RAM; only the
  // read register below is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < ENT_PER_BEAT; k++) begin
        r_mem[w_base + IN_BITS'(k)] <= i_wdata[OUT_BITS*k +: OUT_BITS];
      end
    end
  end

  // Non-blocking update against the same-edge write gives read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron. A config stream loads a 2^IN_BITS-entry
// truth table; once resident, lookups return table[in_data] one cycle later.
//   clk, rst   : clock; synchronous active-high reset
//   cfg_valid  : config beat valid (cfg_ready is always 1)
//   cfg_ready  : config beat accept
//   cfg_data   : packed entries for base = beat*ENT_PER_BEAT
//   cfg_last   : final beat of a table
//   in_valid   : lookup request
//   in_ready   : lookup accept, high only while a table is resident
//   in_data    : lookup address
//   out_valid  : single-cycle result strobe
//   out_data   : looked-up entry, holds between results
//   programmed : complete, well-formed table resident
//   cfg_err    : sticky malformed-load flag, cleared by the next first beat
module lut_neuron_prog
  import lut_prog_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int CFG_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                programmed,
  output logic                cfg_err
);

  localparam int BEATS = calc_beats(IN_BITS, CFG_W, OUT_BITS);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic             r_out_valid;

  logic             w_cfg_acc;
  logic             w_in_acc;
  logic [CNT_W-1:0] w_waddr;
  logic             w_final;

  assign cfg_ready = 1'b1;
  assign in_ready  = (r_state == RUN);
  assign w_cfg_acc = cfg_valid && cfg_ready;
  assign w_in_acc  = in_valid && in_ready;

  // Outside LOAD every accepted beat is a first beat, so it writes base 0.
  assign w_waddr = (r_state == LOAD) ? r_cnt : '0;
  // LAST_CNT is 0 for a single-beat table, so a first beat can also be final.
  assign w_final = (w_waddr == LAST_CNT);

  // NOTE: every output of this block is given a default first so that no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    if (w_cfg_acc) begin
      w_state_nxt = EMPTY;
      w_cnt_nxt   = '0;
      if (cfg_last && w_final) begin
        w_state_nxt = RUN;
        w_err_nxt   = 1'b0;
      end else if (cfg_last || w_final) begin
        // Early cfg_last, or the final beat arrived without it.
        w_err_nxt   = 1'b1;
      end else begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = w_waddr + CNT_W'(1);
        w_err_nxt   = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
      r_out_valid <= w_in_acc;
    end
  end

  lut_prog_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CFG_W    (CFG_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_cfg_acc && !rst),
    .i_waddr (w_waddr),
    .i_wdata (cfg_data),
    .i_re    (w_in_acc && !rst),
    .i_raddr (in_data),
    .o_rdata (out_data)
  );

  assign out_valid  = r_out_valid;
  assign programmed = (r_state == RUN);
  assign cfg_err    = r_err;

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Directed testbench for lut_neuron_prog at default parameters
// (IN_BITS=8, OUT_BITS=1, CFG_W=8, 32 beats per table).
module tb_lut_neuron_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic [0:0] out_data;
  logic       programmed;
  logic       cfg_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [255:0] tbl_pc;
  logic [255:0] tbl_ones;
  logic [255:0] tbl_zero;

  lut_neuron_prog dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .programmed (programmed),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams beats [first, stop) of tbl; cfg_last on beat last_at (-1: never).
  task automatic load_range(input logic [255:0] tbl, input int first,
                            input int stop, input int last_at);
    for (int b = first; b < stop; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = tbl[b*8 +: 8];
      cfg_last  = (b == last_at);
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] addr, input logic expv, input string name);
    in_valid = 1'b1;
    in_data  = addr;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, out_data} !== {1'b1, expv}) begin
      $display("FAIL %s: got valid/data %b expected %b", name, {out_valid, out_data}, {1'b1, expv});
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    tick();
    tick();
    n_total++;
    if ({cfg_ready, in_ready, out_valid, out_data, programmed, cfg_err} !== 6'b100000) begin
      $display("FAIL reset_state: got %b expected %b",
               {cfg_ready, in_ready, out_valid, out_data, programmed, cfg_err}, 6'b100000);
    end else begin
      n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_load_and_lookup();
    load_range(tbl_pc, 0, 31, -1);
    n_total++;
    if (programmed !== 1'b0) begin
      $display("FAIL programmed_before_last: got %b expected 0", programmed);
    end else begin
      n_pass++;
    end
    load_range(tbl_pc, 31, 32, 31);
    n_total++;
    if ({programmed, in_ready, cfg_err} !== 3'b110) begin
      $display("FAIL load_complete: got %b expected 110", {programmed, in_ready, cfg_err});
    end else begin
      n_pass++;
    end
    lookup(8'h00, 1'b0, "lookup_00");
    lookup(8'h0F, 1'b1, "lookup_0f");
    lookup(8'h07, 1'b0, "lookup_07");
    lookup(8'hFF, 1'b1, "lookup_ff");
    tick();
    n_total++;
    if ({out_valid, out_data} !== 2'b01) begin
      $display("FAIL pulse_and_hold: got %b expected 01", {out_valid, out_data});
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      n_total++;
      if ({out_valid, out_data} !== {1'b1, tbl_pc[i]}) begin
        errs++;
        if (errs <= 5) begin
          $display("FAIL b2b_%0d: got %b expected %b", i, {out_valid, out_data}, {1'b1, tbl_pc[i]});
        end
      end else begin
        n_pass++;
      end
    end
    in_valid = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_end_valid: got %b expected 0", out_valid);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_early_last();
    load_range(tbl_pc, 0, 11, 10);
    n_total++;
    if ({cfg_err, programmed, in_ready} !== 3'b100) begin
      $display("FAIL early_last: got %b expected 100", {cfg_err, programmed, in_ready});
    end else begin
      n_pass++;
    end
    load_range(tbl_pc, 0, 1, -1);
    n_total++;
    if ({cfg_err, programmed} !== 2'b00) begin
      $display("FAIL err_clear_first_beat: got %b expected 00", {cfg_err, programmed});
    end else begin
      n_pass++;
    end
    load_range(tbl_pc, 1, 32, 31);
    n_total++;
    if ({cfg_err, programmed} !== 2'b01) begin
      $display("FAIL reload_after_err: got %b expected 01", {cfg_err, programmed});
    end else begin
      n_pass++;
    end
    lookup(8'h1E, 1'b1, "lookup_1e_after_err");
  endtask

  task automatic test_read_before_write();
    load_range(tbl_ones, 0, 32, 31);
    // First reload beat and lookup of an address inside that beat together.
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    cfg_last  = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h03;
    tick();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    n_total++;
    if ({out_valid, out_data, programmed, in_ready} !== 4'b1100) begin
      $display("FAIL rbw_old_value: got %b expected 1100",
               {out_valid, out_data, programmed, in_ready});
    end else begin
      n_pass++;
    end
    load_range(tbl_zero, 1, 32, 31);
    lookup(8'h03, 1'b0, "rbw_new_03");
    lookup(8'hFF, 1'b0, "rbw_new_ff");
  endtask

  task automatic test_missing_last();
    load_range(tbl_pc, 0, 32, -1);
    n_total++;
    if ({cfg_err, programmed, in_ready} !== 3'b100) begin
      $display("FAIL missing_last: got %b expected 100", {cfg_err, programmed, in_ready});
    end else begin
      n_pass++;
    end
    load_range(tbl_pc, 0, 1, -1);
    n_total++;
    if ({cfg_err, programmed} !== 2'b00) begin
      $display("FAIL beat33_first: got %b expected 00", {cfg_err, programmed});
    end else begin
      n_pass++;
    end
    load_range(tbl_pc, 1, 32, 31);
    n_total++;
    if ({cfg_err, programmed} !== 2'b01) begin
      $display("FAIL load_after_missing: got %b expected 01", {cfg_err, programmed});
    end else begin
      n_pass++;
    end
    lookup(8'hFF, 1'b1, "lookup_ff_after_missing");
  endtask

  task automatic test_reset_mid_load();
    load_range(tbl_pc, 0, 16, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if ({cfg_ready, in_ready, out_valid, out_data, programmed, cfg_err} !== 6'b100000) begin
      $display("FAIL reset_mid_load: got %b expected %b",
               {cfg_ready, in_ready, out_valid, out_data, programmed, cfg_err}, 6'b100000);
    end else begin
      n_pass++;
    end
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({in_ready, out_valid} !== 2'b00) begin
      $display("FAIL lookup_blocked: got %b expected 00", {in_ready, out_valid});
    end else begin
      n_pass++;
    end
    load_range(tbl_pc, 0, 32, 31);
    n_total++;
    if (programmed !== 1'b1) begin
      $display("FAIL reload_after_rst: got %b expected 1", programmed);
    end else begin
      n_pass++;
    end
    lookup(8'h0F, 1'b1, "lookup_0f_after_rst");
    lookup(8'h70, 1'b0, "lookup_70_after_rst");
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      tbl_pc[x] = ($countones(8'(x)) >= 4);
    end
    tbl_ones = '1;
    tbl_zero = '0;

    test_reset();
    test_load_and_lookup();
    test_back_to_back();
    test_early_last();
    test_read_before_write();
    test_missing_last();
    test_reset_mid_load();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
